// File: rtl/latch_bank_pkg.sv
// Shared types and pin-field positions for the latch bank controller.
// Optional parity feature is enabled by defining LATCH_PARITY_EN.
package latch_bank_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'b00,
        OP_READ   = 2'b01,
        OP_FOLLOW = 2'b10,
        OP_CLEAR  = 2'b11
    } opcode_e;

    typedef enum logic [1:0] {
        IDLE   = 2'b00,
        FOLLOW = 2'b01,
        CLEAR  = 2'b10
    } state_e;

    localparam int STB_BIT  = 7;
    localparam int OP_MSB   = 6;
    localparam int OP_LSB   = 5;
    localparam int BUSY_BIT = 7;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-stage input synchroniser for a bus, plus a rising-edge pulse on one
// selected bit (the strobe) taken from the synchronised output.
module sync_edge_det #(
    parameter int WIDTH   = 16,
    parameter int STAGES  = 2,
    parameter int STB_IDX = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             pulse
);

    logic [WIDTH-1:0] sync_q [STAGES];
    logic             stb_prev;

    // NOTE: sequential state uses non-blocking assignments so every stage
    // samples the value its predecessor held before this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int s = 0; s < STAGES; s++) begin
                sync_q[s] <= '0;
            end
            stb_prev <= 1'b0;
        end else begin
            sync_q[0] <= din;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
            stb_prev <= sync_q[STAGES-1][STB_IDX];
        end
    end

    assign dout  = sync_q[STAGES-1];
    assign pulse = dout[STB_IDX] & ~stb_prev;

endmodule

// File: rtl/latch_bank_ctrl.sv
// Strobe-commanded bank of NUM_CH x WIDTH storage channels (write, read,
// follow, clear-all sweep). Define LATCH_PARITY_EN for per-channel parity.
module latch_bank_ctrl
    import latch_bank_pkg::*;
#(
    parameter int NUM_CH      = 8,
    parameter int WIDTH       = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    input  logic [7:0] uio_in,
    output logic [7:0] uo_out,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int              IDX_W   = $clog2(NUM_CH);
    localparam logic [IDX_W-1:0] LAST_CH = IDX_W'(NUM_CH - 1);

    logic [15:0]      synced;
    logic             strobe_pulse;
    logic [7:0]       sync_ui;
    logic [7:0]       sync_uio;
    opcode_e          cmd_op;
    logic [IDX_W-1:0] cmd_idx;
    logic [WIDTH-1:0] cmd_data;
    logic             cmd_valid;
    logic             busy;
    logic             unused_bits;

    state_e           state;
    state_e           state_next;
    logic [WIDTH-1:0] ch_mem [NUM_CH];
    logic [WIDTH-1:0] rd_reg;
    logic [IDX_W-1:0] follow_idx;
    logic [IDX_W-1:0] sweep_cnt;
    logic [6:0]       rd_ext;

    // Data and control share one synchroniser so they stay aligned with the strobe.
    sync_edge_det #(
        .WIDTH   (16),
        .STAGES  (SYNC_STAGES),
        .STB_IDX (STB_BIT)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .din   ({uio_in, ui_in}),
        .dout  (synced),
        .pulse (strobe_pulse)
    );

    assign sync_ui     = synced[7:0];
    assign sync_uio    = synced[15:8];
    assign cmd_op      = opcode_e'(sync_ui[OP_MSB:OP_LSB]);
    assign cmd_idx     = sync_ui[IDX_W-1:0];
    assign cmd_data    = sync_uio[WIDTH-1:0];
    assign busy        = (state == CLEAR);
    assign cmd_valid   = strobe_pulse & ena & ~busy;
    assign unused_bits = ^{sync_ui, sync_uio};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: next-state gets a default before any branch so no latch is inferred.
    always_comb begin
        state_next = state;
        if (cmd_valid) begin
            case (cmd_op)
                OP_FOLLOW: state_next = FOLLOW;
                OP_CLEAR:  state_next = CLEAR;
                default:   state_next = IDLE;
            endcase
        end else if (busy && (sweep_cnt == LAST_CH)) begin
            state_next = IDLE;
        end
    end

    // NOTE: the channel array is reset explicitly; a clear after reset must
    // never expose power-up contents, so it is built from flops, not RAM.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                ch_mem[k] <= '0;
            end
            rd_reg     <= '0;
            follow_idx <= '0;
            sweep_cnt  <= '0;
        end else if (cmd_valid) begin
            // A new command pre-empts the follow write in its own cycle.
            case (cmd_op)
                OP_WRITE:  ch_mem[cmd_idx] <= cmd_data;
                OP_READ:   rd_reg <= ch_mem[cmd_idx];
                OP_FOLLOW: begin
                    ch_mem[cmd_idx] <= cmd_data;
                    follow_idx      <= cmd_idx;
                end
                default:   sweep_cnt <= '0;
            endcase
        end else if (state == FOLLOW) begin
            ch_mem[follow_idx] <= cmd_data;
        end else if (busy) begin
            ch_mem[sweep_cnt] <= '0;
            sweep_cnt         <= sweep_cnt + 1'b1;
            if (sweep_cnt == LAST_CH) begin
                rd_reg <= '0;
            end
        end
    end

    always_comb begin
        rd_ext              = '0;
        rd_ext[WIDTH-1:0]   = rd_reg;
    end

    assign uo_out = {busy, rd_ext};

`ifdef LATCH_PARITY_EN
    logic par_mem [NUM_CH];
    logic parity_err;

    // Even parity: stored bit equals XOR of the data, so data^par is always 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < NUM_CH; k++) begin
                par_mem[k] <= 1'b0;
            end
            parity_err <= 1'b0;
        end else if (cmd_valid) begin
            case (cmd_op)
                OP_WRITE, OP_FOLLOW: par_mem[cmd_idx] <= ^cmd_data;
                OP_READ: begin
                    if ((^ch_mem[cmd_idx]) != par_mem[cmd_idx]) begin
                        parity_err <= 1'b1;
                    end
                end
                default: ;
            endcase
        end else if (state == FOLLOW) begin
            par_mem[follow_idx] <= ^cmd_data;
        end else if (busy) begin
            par_mem[sweep_cnt] <= 1'b0;
            if (sweep_cnt == LAST_CH) begin
                parity_err <= 1'b0;
            end
        end
    end

    assign uio_out = {parity_err, 7'b0};
    assign uio_oe  = 8'h80;
`else
    assign uio_out = 8'h00;
    assign uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_latch_bank_ctrl.sv
// Self-checking bench for latch_bank_ctrl: directed scenarios plus randomized
// commands compared against a channel-array reference model.
module tb_latch_bank_ctrl;
    import latch_bank_pkg::*;

    localparam int NUM_CH      = 8;
    localparam int WIDTH       = 7;
    localparam int SYNC_STAGES = 2;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int tests_run    = 0;
    int tests_failed = 0;

    // Reference model: what each channel and the read register should hold.
    logic [6:0] model_mem [NUM_CH];
    logic [6:0] model_rd;
    bit         follow_on;
    int         follow_ch;

    always #5 clk = ~clk;

    latch_bank_ctrl #(
        .NUM_CH      (NUM_CH),
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uio_in  (uio_in),
        .uo_out  (uo_out),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    task automatic check(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        tests_run++;
        assert (observed === expected) else begin
            tests_failed++;
            $error("FAIL %s: observed 0x%02h expected 0x%02h", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NUM_CH; k++) model_mem[k] = '0;
        model_rd  = '0;
        follow_on = 1'b0;
        follow_ch = 0;
    endtask

    task automatic model_apply(input logic [1:0] op, input int ch, input logic [6:0] d);
        case (op)
            2'b00: model_mem[ch] = d;
            2'b01: model_rd = model_mem[ch];
            2'b10: begin
                model_mem[ch] = d;
                follow_on     = 1'b1;
                follow_ch     = ch;
            end
            default: begin
                for (int k = 0; k < NUM_CH; k++) model_mem[k] = '0;
                model_rd = '0;
            end
        endcase
        if (op != 2'b10) follow_on = 1'b0;
    endtask

    // Issue one command from a negedge; returns at a negedge once it has settled.
    task automatic do_cmd(input logic [1:0] op, input logic [4:0] idx, input logic [7:0] data, input int hold);
        bit accept;
        accept = ena;
        ui_in  = {1'b1, op, idx};
        uio_in = data;
        repeat (hold) @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        if (accept && op == 2'b11) repeat (NUM_CH + 2) @(negedge clk);
        if (accept) model_apply(op, int'(idx[3:0]) % NUM_CH, data[6:0]);
        else if (follow_on) model_mem[follow_ch] = data[6:0];
    endtask

    task automatic follow_drive(input logic [7:0] data);
        uio_in = data;
        repeat (4) @(negedge clk);
        if (follow_on) model_mem[follow_ch] = data[6:0];
    endtask

    task automatic read_check(input int ch, input string tag);
        do_cmd(OP_READ, 5'(ch), 8'($urandom), 1);
        check(tag, uo_out, {1'b0, model_rd});
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
        $fatal(1);
    end

    initial begin
        int busy_cnt;
        int cyc;
        logic [1:0] rop;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;
        model_reset();
        #2;
        check("reset_uo_out", uo_out, 8'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        check("reset_uio_out", uio_out, 8'h00);
`ifdef LATCH_PARITY_EN
        check("reset_uio_oe", uio_oe, 8'h80);
`else
        check("reset_uio_oe", uio_oe, 8'h00);
`endif

        // WRITE ch3 then READ ch3 with exact edge latency.
        do_cmd(OP_WRITE, 5'd3, 8'h55, 1);
        ui_in  = {1'b1, OP_READ, 5'd3};
        uio_in = 8'h00;
        @(posedge clk);
        @(posedge clk);
        #1 check("read_lat_edge2", uo_out, 8'h00);
        @(posedge clk);
        #1 check("read_lat_edge3", uo_out, 8'h55);
        @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        model_rd = model_mem[3];
        check("read_ch3_settled", uo_out, 8'h55);

        // WRITE ch0, read it back, then sweep with a READ attempted mid-sweep.
        do_cmd(OP_WRITE, 5'd0, 8'h7F, 1);
        read_check(0, "read_ch0_pre_clear");
        busy_cnt = 0;
        for (int c = 0; c < 30; c++) begin
            case (c)
                0: ui_in = {1'b1, OP_CLEAR, 5'd0};
                1: ui_in[7] = 1'b0;
                5: ui_in = {1'b1, OP_READ, 5'd0};
                6: ui_in[7] = 1'b0;
                default: ;
            endcase
            @(negedge clk);
            if (uo_out[BUSY_BIT]) busy_cnt++;
            if (c == 7) check("read_ignored_mid_sweep", uo_out, 8'hFF);
        end
        model_apply(OP_CLEAR, 0, 7'd0);
        check("busy_cycles", 8'(busy_cnt), 8'(NUM_CH));
        check("post_sweep_uo_out", uo_out, 8'h00);
        read_check(0, "read_ch0_post_clear");

        // FOLLOW ch5 with changing data, then WRITE ends following.
        do_cmd(OP_FOLLOW, 5'd5, 8'h11, 1);
        follow_drive(8'h22);
        follow_drive(8'h33);
        do_cmd(OP_WRITE, 5'd5, 8'h44, 1);
        follow_drive(8'h66);
        read_check(5, "follow_then_write_ch5");

        // Following ch2, a WRITE elsewhere leaves ch2 with the last followed value.
        do_cmd(OP_FOLLOW, 5'd2, 8'h21, 1);
        follow_drive(8'h5A);
        do_cmd(OP_WRITE, 5'd6, 8'h01, 1);
        follow_drive(8'h0F);
        read_check(2, "follow_ch2_retained");
        read_check(6, "write_ch6_during_follow");

        // Strobe held 10 cycles: only the first sampled data is written.
        ui_in  = {1'b1, OP_WRITE, 5'd1};
        uio_in = 8'h0A;
        repeat (5) @(negedge clk);
        uio_in = 8'h15;
        repeat (5) @(negedge clk);
        ui_in[7] = 1'b0;
        repeat (4) @(negedge clk);
        model_mem[1] = 7'h0A;
        read_check(1, "held_strobe_single_write");

        // ena low blocks new commands.
        ena = 1'b0;
        do_cmd(OP_WRITE, 5'd1, 8'h33, 1);
        do_cmd(OP_READ, 5'd3, 8'h00, 1);
        check("ena_low_read_blocked", uo_out, {1'b0, model_rd});
        ena = 1'b1;
        read_check(1, "ena_low_write_blocked");

        // Randomized commands, index bits above log2(NUM_CH) and bit 4 random.
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 2));
            do_cmd(rop, 5'($urandom), 8'($urandom), $urandom_range(1, 3));
            if (rop == OP_FOLLOW) begin
                follow_drive(8'($urandom));
                follow_drive(8'($urandom));
            end
            check("rand_cmd_uo_out", uo_out, {1'b0, model_rd});
            read_check($urandom_range(0, NUM_CH - 1), "rand_read");
        end

        // Fill all channels, then reset asynchronously on sweep cycle 4.
        for (int k = 0; k < NUM_CH; k++) do_cmd(OP_WRITE, 5'(k), 8'(8'h40 + k), 1);
        read_check(7, "fill_ch7");
        ui_in = {1'b1, OP_CLEAR, 5'd0};
        cyc   = 0;
        while (!uo_out[BUSY_BIT] && cyc < 10) begin
            @(negedge clk);
            cyc++;
        end
        check("sweep_started", {7'd0, uo_out[BUSY_BIT]}, 8'h01);
        ui_in[7] = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_reset_mid_sweep", uo_out, 8'h00);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        for (int k = 0; k < NUM_CH; k++) read_check(k, "post_reset_channel");
        check("post_reset_busy", {7'd0, uo_out[BUSY_BIT]}, 8'h00);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
